// File: rtl/seq_shifter_pkg.sv
// Shared definitions for seq_shifter: mode encodings, FSM state type and a
// small decode helper used by both the top and the testbench.
package shifter_pkg;

  localparam logic [2:0] SH_PASS = 3'b000;
  localparam logic [2:0] SH_ASR  = 3'b001;
  localparam logic [2:0] SH_LSR  = 3'b010;
  localparam logic [2:0] SH_LSL  = 3'b011;
  localparam logic [2:0] SH_ROR  = 3'b100;
  localparam logic [2:0] SH_ROL  = 3'b101;
  localparam logic [2:0] SH_SWAP = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sh_state_t;

  // Modes whose step count comes from amt (everything except pass and swap).
  function automatic logic is_shift_mode(input logic [2:0] sel);
    return (sel >= SH_ASR) && (sel <= SH_ROL);
  endfunction

endpackage

// File: rtl/seq_shifter_if.sv
// Request/result bundle between a requester (master) and seq_shifter (slave).
interface seq_shifter_if #(
  parameter int BW = 16
);
  localparam int SHW = $clog2(BW);

  logic           start;
  logic [BW-1:0]  din;
  logic [2:0]     sel;
  logic [SHW-1:0] amt;
  logic           inR;
  logic           inL;
  logic           busy;
  logic           done;
  logic [BW-1:0]  dout;
  logic           cout;
  logic           zero;

  modport master (
    output start, din, sel, amt, inR, inL,
    input  busy, done, dout, cout, zero
  );

  modport slave (
    input  start, din, sel, amt, inR, inL,
    output busy, done, dout, cout, zero
  );

endinterface

// File: rtl/seq_shifter_step.sv
// Combinational single-position shift/rotate step; the iterative datapath
// applies it once per clock, the barrel build chains copies of it.
module shift_step
  import shifter_pkg::*;
#(
  parameter int BW = 16
) (
  input  logic [BW-1:0] din,
  input  logic [2:0]    sel,
  input  logic          inR,
  input  logic          inL,
  output logic [BW-1:0] dout,
  output logic          cout
);

  logic [BW-1:0] swapped;

  for (genvar gi = 0; gi < BW / 8; gi++) begin : g_swap
    assign swapped[gi*8 +: 8] = {din[gi*8 +: 4], din[gi*8+4 +: 4]};
  end

  always_comb begin
    dout = din;
    cout = 1'b0;
    case (sel)
      SH_ASR: begin
        dout = {din[BW-1], din[BW-1:1]};
        cout = din[0];
      end
      SH_LSR: begin
        dout = {inR, din[BW-1:1]};
        cout = din[0];
      end
      SH_LSL: begin
        dout = {din[BW-2:0], inL};
        cout = din[BW-1];
      end
      SH_ROR: begin
        dout = {din[0], din[BW-1:1]};
        cout = din[0];
      end
      SH_ROL: begin
        dout = {din[BW-2:0], din[BW-1]};
        cout = din[BW-1];
      end
      SH_SWAP: dout = swapped;
      default: dout = din;
    endcase
  end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shift/rotate unit: one bit position per clock behind start/done.
// Define SEQ_SHIFTER_BARREL_EN to resolve the whole shift in the load cycle.
module seq_shifter
  import shifter_pkg::*;
#(
  parameter int BW = 16
) (
  input logic          clk,
  input logic          rst_n,
  seq_shifter_if.slave bus
);

  localparam int SHW = $clog2(BW);

  sh_state_t      state_reg;
  logic [BW-1:0]  dout_reg;
  logic [2:0]     sel_reg;
  logic           inr_reg;
  logic           inl_reg;
  logic           cout_reg;
  logic           zero_reg;
  logic           busy_reg;
  logic           done_reg;
  logic [SHW-1:0] cnt_reg;

  logic [SHW-1:0] load_cnt;
  logic [BW-1:0]  load_dout;
  logic           load_cout;
  logic           go_run;
  logic [BW-1:0]  step_dout;
  logic           step_cout;

  // Swap is a single step; pass needs none.
  always_comb begin
    load_cnt = '0;
    if (is_shift_mode(bus.sel)) begin
      load_cnt = bus.amt;
    end else if (bus.sel == SH_SWAP) begin
      load_cnt = SHW'(1);
    end
  end

  shift_step #(.BW(BW)) u_step (
    .din  (dout_reg),
    .sel  (sel_reg),
    .inR  (inr_reg),
    .inL  (inl_reg),
    .dout (step_dout),
    .cout (step_cout)
  );

`ifdef SEQ_SHIFTER_BARREL_EN
  // Unrolled step chain: stage gi is active only while gi < load_cnt, so the
  // result and last bit out match the iterative build exactly.
  logic [BW-1:0][BW-1:0] chain_d;
  logic [BW-1:0]         chain_c;

  assign chain_d[0] = bus.din;
  assign chain_c[0] = 1'b0;

  for (genvar gi = 0; gi < BW - 1; gi++) begin : g_chain
    logic [BW-1:0] st_dout;
    logic          st_cout;

    shift_step #(.BW(BW)) u_stage (
      .din  (chain_d[gi]),
      .sel  (bus.sel),
      .inR  (bus.inR),
      .inL  (bus.inL),
      .dout (st_dout),
      .cout (st_cout)
    );

    assign chain_d[gi+1] = (SHW'(gi) < load_cnt) ? st_dout : chain_d[gi];
    assign chain_c[gi+1] = (SHW'(gi) < load_cnt) ? st_cout : chain_c[gi];
  end

  assign load_dout = chain_d[BW-1];
  assign load_cout = chain_c[BW-1];
  assign go_run    = 1'b0;
`else
  assign load_dout = bus.din;
  assign load_cout = 1'b0;
  assign go_run    = (load_cnt != '0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      dout_reg  <= '0;
      sel_reg   <= SH_PASS;
      inr_reg   <= 1'b0;
      inl_reg   <= 1'b0;
      cout_reg  <= 1'b0;
      zero_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        RUN: begin
          dout_reg <= step_dout;
          cout_reg <= step_cout;
          cnt_reg  <= cnt_reg - SHW'(1);
          if (cnt_reg == SHW'(1)) begin
            state_reg <= DONE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            zero_reg  <= (step_dout == '0);
          end
        end
        default: begin
          // IDLE and DONE both accept a new request, giving back-to-back issue.
          if (bus.start) begin
            sel_reg  <= bus.sel;
            inr_reg  <= bus.inR;
            inl_reg  <= bus.inL;
            dout_reg <= load_dout;
            cout_reg <= load_cout;
            if (go_run) begin
              state_reg <= RUN;
              busy_reg  <= 1'b1;
              cnt_reg   <= load_cnt;
            end else begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
              zero_reg  <= (load_dout == '0);
              cnt_reg   <= '0;
            end
          end else begin
            state_reg <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.busy = busy_reg;
  assign bus.done = done_reg;
  assign bus.dout = dout_reg;
  assign bus.cout = cout_reg;
  assign bus.zero = zero_reg;

endmodule

// File: tb/tb_seq_shifter.sv
// Self-checking bench for seq_shifter: directed table, randomized ops against
// an arithmetic reference model, back-to-back issue and mid-run reset.
module tb_seq_shifter;
  import shifter_pkg::*;

  localparam int BW = 16;
`ifdef SEQ_SHIFTER_BARREL_EN
  localparam bit BARREL = 1'b1;
`else
  localparam bit BARREL = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seq_shifter_if #(.BW(BW)) bus ();

  seq_shifter #(.BW(BW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  sel;
    logic [15:0] din;
    logic [3:0]  amt;
    logic        ir;
    logic        il;
    logic [15:0] exp_dout;
    logic        exp_cout;
    logic        exp_zero;
    int          exp_lat;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Reference result {cout, dout} from the mode definitions, using whole-word arithmetic.
  function automatic logic [16:0] model(input logic [2:0] sel, input logic [15:0] d,
                                        input int k, input logic ir, input logic il);
    logic [15:0] r;
    logic [15:0] ones;
    logic [31:0] w;
    logic        c;
    ones = '1;
    r = d;
    c = 1'b0;
    case (sel)
      SH_ASR: begin
        r = 16'($signed(d) >>> k);
        if (k > 0) c = d[k-1];
      end
      SH_LSR: begin
        r = d >> k;
        if (ir) r = r | ~(ones >> k);
        if (k > 0) c = d[k-1];
      end
      SH_LSL: begin
        r = d << k;
        if (il) r = r | 16'((32'd1 << k) - 32'd1);
        if (k > 0) c = d[16-k];
      end
      SH_ROR: begin
        w = {d, d} >> k;
        r = w[15:0];
        if (k > 0) c = d[k-1];
      end
      SH_ROL: begin
        w = {d, d} << k;
        r = w[31:16];
        if (k > 0) c = d[16-k];
      end
      SH_SWAP: r = {d[11:8], d[15:12], d[3:0], d[7:4]};
      default: r = d;
    endcase
    return {c, r};
  endfunction

  function automatic int lat_of(input logic [2:0] sel, input logic [3:0] amt);
    if (BARREL) return 1;
    if (sel >= SH_ASR && sel <= SH_ROL) return int'(amt) + 1;
    if (sel == SH_SWAP) return 2;
    return 1;
  endfunction

  task automatic do_op(input string tag, input logic [2:0] sel, input logic [15:0] din,
                       input logic [3:0] amt, input logic ir, input logic il,
                       input logic [15:0] ed, input logic ec, input logic ez, input int el);
    int   lat;
    logic overlap;
    logic saw_busy;
    @(negedge clk);
    bus.start = 1'b1;
    bus.sel   = sel;
    bus.din   = din;
    bus.amt   = amt;
    bus.inR   = ir;
    bus.inL   = il;
    @(posedge clk);
    #1;
    // Inputs are scrambled after the sample edge; they must have no effect.
    bus.start = 1'b0;
    bus.din   = 16'($urandom);
    bus.sel   = 3'($urandom);
    bus.amt   = 4'($urandom);
    bus.inR   = 1'($urandom);
    bus.inL   = 1'($urandom);
    lat = 1;
    overlap = 1'b0;
    saw_busy = 1'b0;
    while (1'b1) begin
      if (bus.busy && bus.done) overlap = 1'b1;
      if (bus.busy) saw_busy = 1'b1;
      if (bus.done || lat > 40) break;
      @(posedge clk);
      #1;
      lat++;
    end
    if (!bus.done) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: done not seen in 40 cycles, required latency %0d", tag, el);
    end else begin
      chk({tag, " latency"}, lat, el);
      chk({tag, " dout"}, bus.dout, ed);
      chk({tag, " cout"}, bus.cout, ec);
      chk({tag, " zero"}, bus.zero, ez);
    end
    $display("op %s sel=%b din=%h amt=%0d -> dout=%h cout=%b zero=%b lat=%0d",
             tag, sel, din, amt, bus.dout, bus.cout, bus.zero, lat);
    chk({tag, " busy&done"}, overlap, 1'b0);
    chk({tag, " busy seen"}, saw_busy, (el > 1));
    @(posedge clk);
    #1;
    chk({tag, " done pulse"}, bus.done, 1'b0);
    chk({tag, " dout hold"}, bus.dout, ed);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [16:0] m;
    logic [15:0] md;
    logic [2:0]  rs;
    logic [15:0] rd;
    logic [3:0]  ra;
    logic        ri;
    logic        rl;

    bus.start = 1'b0;
    bus.din   = '0;
    bus.sel   = SH_PASS;
    bus.amt   = '0;
    bus.inR   = 1'b0;
    bus.inL   = 1'b0;
    rst_n     = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    chk("reset busy", bus.busy, 1'b0);
    chk("reset done", bus.done, 1'b0);
    chk("reset dout", bus.dout, 16'h0000);
    chk("reset cout", bus.cout, 1'b0);
    chk("reset zero", bus.zero, 1'b0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;

    vecs[0] = '{SH_ASR,  16'h8001, 4'd3,  1'b0, 1'b0, 16'hF000, 1'b0, 1'b0, 4};
    vecs[1] = '{SH_LSL,  16'h8000, 4'd2,  1'b0, 1'b1, 16'h0003, 1'b0, 1'b0, 3};
    vecs[2] = '{SH_ROR,  16'h0001, 4'd1,  1'b0, 1'b0, 16'h8000, 1'b1, 1'b0, 2};
    vecs[3] = '{SH_SWAP, 16'h12AB, 4'd7,  1'b0, 1'b0, 16'h21BA, 1'b0, 1'b0, 2};
    vecs[4] = '{SH_LSR,  16'h0000, 4'd0,  1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1};
    vecs[5] = '{SH_ROL,  16'h8421, 4'd4,  1'b0, 1'b0, 16'h4218, 1'b0, 1'b0, 5};
    vecs[6] = '{3'b111,  16'hABCD, 4'd9,  1'b1, 1'b1, 16'hABCD, 1'b0, 1'b0, 1};
    vecs[7] = '{SH_LSR,  16'h0F0F, 4'd4,  1'b1, 1'b0, 16'hF0F0, 1'b1, 1'b0, 5};

    for (int i = 0; i < 8; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i].sel, vecs[i].din, vecs[i].amt, vecs[i].ir,
            vecs[i].il, vecs[i].exp_dout, vecs[i].exp_cout, vecs[i].exp_zero,
            BARREL ? 1 : vecs[i].exp_lat);
    end

    for (int i = 0; i < 120; i++) begin
      rs = 3'($urandom);
      rd = (($urandom_range(0, 9)) == 0) ? 16'h0000 : 16'($urandom);
      ra = 4'($urandom);
      ri = 1'($urandom);
      rl = 1'($urandom);
      m = model(rs, rd, int'(ra), ri, rl);
      do_op($sformatf("rnd%0d", i), rs, rd, ra, ri, rl, m[15:0], m[16], (m[15:0] == 16'h0),
            lat_of(rs, ra));
    end

    // Back-to-back: start held across two consecutive edges, each must complete.
    rd = 16'($urandom);
    ra = BARREL ? 4'd4 : 4'd0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.sel = SH_ROL;
    bus.din = 16'h8421;
    bus.amt = ra;
    @(posedge clk);
    #1;
    m = model(SH_ROL, 16'h8421, int'(ra), 1'b0, 1'b0);
    chk("b2b first done", bus.done, 1'b1);
    chk("b2b first dout", bus.dout, m[15:0]);
    bus.sel = SH_ASR;
    bus.din = rd;
    @(posedge clk);
    #1;
    m = model(SH_ASR, rd, int'(ra), 1'b0, 1'b0);
    chk("b2b second done", bus.done, 1'b1);
    chk("b2b second dout", bus.dout, m[15:0]);
    chk("b2b second cout", bus.cout, m[16]);
    $display("op b2b ROL/ASR amt=%0d -> dout=%h cout=%b", ra, bus.dout, bus.cout);
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    chk("b2b done drop", bus.done, 1'b0);

`ifndef SEQ_SHIFTER_BARREL_EN
    // Long LSR: a start mid-run is ignored, then an async reset aborts it.
    rd = 16'($urandom);
    ri = 1'($urandom);
    @(negedge clk);
    bus.start = 1'b1;
    bus.sel = SH_LSR;
    bus.din = rd;
    bus.amt = 4'd15;
    bus.inR = ri;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk);
      #1;
    end
    bus.start = 1'b1;
    bus.sel = SH_PASS;
    bus.din = ~rd;
    bus.amt = 4'd0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    m = model(SH_LSR, rd, 6, ri, 1'b0);
    chk("midrun busy", bus.busy, 1'b1);
    chk("midrun ignored start done", bus.done, 1'b0);
    chk("midrun dout step6", bus.dout, m[15:0]);
    chk("midrun cout step6", bus.cout, m[16]);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    m = model(SH_LSR, rd, 8, ri, 1'b0);
    chk("midrun dout step8", bus.dout, m[15:0]);
    #2 rst_n = 1'b0;
    #1;
    chk("midrun rst busy", bus.busy, 1'b0);
    chk("midrun rst done", bus.done, 1'b0);
    chk("midrun rst dout", bus.dout, 16'h0000);
    chk("midrun rst cout", bus.cout, 1'b0);
    chk("midrun rst zero", bus.zero, 1'b0);
    $display("op midrun LSR din=%h reset at cycle 8 -> dout=%h busy=%b", rd, bus.dout, bus.busy);
    @(negedge clk);
    rst_n = 1'b1;
    md = 16'h0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) md = 16'h1;
    end
    chk("midrun idle after reset", md, 16'h0);
    do_op("post-reset", SH_ROR, 16'h0001, 4'd1, 1'b0, 1'b0, 16'h8000, 1'b1, 1'b0, 2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_shifter.md
# seq_shifter

Parametrised, multi-cycle shift/rotate unit for the 16-bit datapath, succeeding the combinational single-bit shifter. It accepts an operand, mode and shift amount under a start/done handshake. It shifts one bit position per clock and reports the result with carry-out and zero flags. It sits beside the ALU and serves multi-bit shift instructions, holding the pipeline via `busy`.

## Interface
- `BW`, 16, datapath width; multiple of 8, ≥ 8.
- `SHW`, `$clog2(BW)`, width of shift amount.
- `clk` input 1, sole clock, rising edge.
- `rst_n` input 1, asynchronous, active-low reset.
- `start` input 1, request; sampled only when not `busy`.
- `din` input BW, operand.
- `sel` input 3, mode.
- `amt` input SHW, shift count 0..BW-1.
- `inR` input 1, fill bit for logical right shift.
- `inL` input 1, fill bit for logical left shift.
- `busy` output 1, operation in progress; new `start` ignored.
- `done` output 1, one-cycle pulse: result valid.
- `dout` output BW, result register.
- `cout` output 1, last bit shifted/rotated out.
- `zero` output 1, `dout == 0`, valid with `done`.

## Operation
- Modes (`sel`):
  - 001: arithmetic right shift.
  - 010: logical right shift, fill `inR`.
  - 011: logical left shift, fill `inL`.
  - 100: rotate right.
  - 101: rotate left.
  - 110: nibble swap in every byte; `amt` ignored.
  - 000/111: pass; `amt` ignored.
- FSM states IDLE, RUN, DONE.
  - IDLE/DONE + `start`: load `din`, `sel`, `inR`, `inL`.
    - Load `cnt = amt` for shift modes, 1 for swap, 0 for pass.
    - Go to RUN if `cnt != 0`, otherwise go to DONE.
  - RUN: each edge applies one step, sets `cout` to the bit leaving the word, and decrements `cnt`. When `cnt` reaches 0, go to DONE.
  - DONE: `done=1` for exactly one cycle, `zero` updated, then IDLE unless `start` is present, which is accepted as in IDLE (back-to-back allowed).
- `cout` is cleared on load. It stays 0 for swap, pass and `amt=0`.
- Inputs are sampled only at an accepted start. Later changes to `din`/`sel`/`amt` have no effect.
- `start` during RUN is ignored, with no queueing.
- `dout` holds its last result until the next accepted start. During RUN it shows intermediate values.

## Timing
- Reset (async, any state including mid-RUN): state IDLE.
  - `busy=0`, `done=0`, `dout=0`, `cout=0`, `zero=0`.
  - `cnt` cleared.
- Latency from the start-sample edge to the `done` cycle:
  - Shift modes: `amt+1` cycles.
  - Swap: 2 cycles.
  - Pass or `amt=0`: 1 cycle.
- `busy` is high in RUN only.
- `done` and `busy` are never high together.
- Maximum latency is BW cycles (`amt=BW-1`).

## Configuration
- `SEQ_SHIFTER_BARREL_EN` defined:
  - The full shift is computed combinationally on load (log2 barrel).
  - The FSM goes IDLE→DONE directly; latency is always 1 cycle and `busy` is never asserted.
  - `cout` is the final bit out, identical to iterative mode.
- Undefined: iterative behaviour as above. Results and flags must be bit-identical between the two builds.

## Structure
- Package `shifter_pkg` holds:
  - Mode localparams `SH_PASS`, `SH_ASR`, `SH_LSR`, `SH_LSL`, `SH_ROR`, `SH_ROL`, `SH_SWAP`.
  - State enum `sh_state_t`.
- Sub-module `shift_step`: combinational single-bit step `(BW; din, sel, inR, inL -> dout, cout)`. The RUN datapath instantiates it once. Barrel mode builds from it or from its own mux tree.

## Test plan
- ASR, `din=16'h8001`, `amt=3` → `done` 4 cycles after start, `dout=16'hF000`, `cout=0`, `zero=0`.
- LSL, `inL=1`, `din=16'h8000`, `amt=2` → `dout=16'h0003`, `cout=0`, latency 3.
- ROR, `din=16'h0001`, `amt=1` → `dout=16'h8000`, `cout=1`, latency 2.
- Swap, `din=16'h12AB`, `sel=110`, `amt=7` → `dout=16'h21BA`, latency 2. LSR `din=0`, `amt=0` → latency 1, `zero=1`, `cout=0`.
- LSR, `amt=15`, second `start` at cycle 5 is ignored. `rst_n` pulsed low at cycle 8 → all outputs 0 immediately and the FSM returns to IDLE.
- With `SEQ_SHIFTER_BARREL_EN`: ROL, `din=16'h8421`, `amt=4` → `dout=16'h4218`, `done` 1 cycle after start, `busy` never high. Back-to-back starts each produce `done`.
